// File: rtl/textmode_pkg.sv
// Shared text-mode constants: tram geometry, word layout, control codes and
// the text_console state encoding.
package textmode_pkg;

   localparam int TRAM_HRES  = 84;
   localparam int TRAM_VRES  = 24;
   localparam int TRAM_ADDRW = 11;

   // tram word field positions
   localparam int GLYPH_LSB = 0;
   localparam int FG_LSB    = 8;
   localparam int BG_LSB    = 12;

   // control codes understood by the console
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_BLANK = 8'h20;

   // console states
   localparam logic [1:0] ST_CLR_ALL  = 2'd0;
   localparam logic [1:0] ST_IDLE     = 2'd1;
   localparam logic [1:0] ST_CLR_LINE = 2'd2;

endpackage

// File: rtl/text_console.sv
// Character-stream front end for text mode: turns a byte stream into tram
// glyph+colour writes, tracking cursor, line wrap, hardware scroll and clears.
module text_console
   import textmode_pkg::*;
#(
   parameter int WORD       = 32,
   parameter int BYTE_CNT   = 4,
   parameter int TRAM_ADDRW = textmode_pkg::TRAM_ADDRW,
   parameter int TRAM_HRES  = textmode_pkg::TRAM_HRES,
   parameter int TRAM_VRES  = textmode_pkg::TRAM_VRES,
   parameter int CIDXW      = 4,
   parameter int FONT_COUNT = 128
) (
   input  logic                  clk_sys,
   input  logic                  rst_sys,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CIDXW-1:0]      colr_fg,
   input  logic [CIDXW-1:0]      colr_bg,
   output logic [BYTE_CNT-1:0]   tram_we,
   output logic [TRAM_ADDRW-1:0] tram_addr,
   output logic [WORD-1:0]       tram_din,
   output logic [TRAM_ADDRW-1:0] scroll_offs,
   output logic [6:0]            cursor_col,
   output logic [4:0]            cursor_row,
   output logic                  busy
);

   localparam int SIZE = TRAM_HRES * TRAM_VRES;
   localparam logic [TRAM_ADDRW:0]   SIZE_X    = (TRAM_ADDRW+1)'(SIZE);
   localparam logic [TRAM_ADDRW-1:0] HRES_A    = TRAM_ADDRW'(TRAM_HRES);
   localparam logic [TRAM_ADDRW-1:0] LAST_WORD = TRAM_ADDRW'(SIZE - 1);
   localparam logic [TRAM_ADDRW-1:0] LAST_LCNT = TRAM_ADDRW'(TRAM_HRES - 1);
   localparam logic [6:0]            LAST_COL  = 7'(TRAM_HRES - 1);
   localparam logic [4:0]            LAST_ROW  = 5'(TRAM_VRES - 1);
   localparam logic [7:0]            PRINT_MAX = 8'((FONT_COUNT - 1 < 'h7E) ? FONT_COUNT - 1 : 'h7E);

   // a + b modulo SIZE; both operands are already below SIZE so one subtract suffices
   function automatic logic [TRAM_ADDRW-1:0] wrap_add(input logic [TRAM_ADDRW-1:0] a,
                                                      input logic [TRAM_ADDRW-1:0] b);
      logic [TRAM_ADDRW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= SIZE_X) s = s - SIZE_X;
      return s[TRAM_ADDRW-1:0];
   endfunction

   function automatic logic [WORD-1:0] mk_word(input logic [7:0] g,
                                               input logic [CIDXW-1:0] f,
                                               input logic [CIDXW-1:0] b);
      logic [WORD-1:0] w;
      w = '0;
      w[GLYPH_LSB +: 8] = g;
      w[FG_LSB +: CIDXW] = f;
      w[BG_LSB +: CIDXW] = b;
      return w;
   endfunction

   logic [1:0]            state;
   logic [6:0]            col;
   logic [4:0]            row;
   logic [TRAM_ADDRW-1:0] line_base;   // (scroll_offs + row*HRES) mod SIZE
   logic [TRAM_ADDRW-1:0] scroll;
   logic [TRAM_ADDRW-1:0] clr_cnt;
   logic                  is_print, is_nl, accept;
   logic [WORD-1:0]       blank;

   assign in_ready    = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);
   assign scroll_offs = scroll;
   assign cursor_col  = col;
   assign cursor_row  = row;
   assign accept      = in_valid && in_ready;
   assign blank       = mk_word(CH_BLANK, colr_fg, colr_bg);

   // decode the incoming byte: printable range and whether it ends the line
   always_comb begin
      is_print = (in_data >= 8'h20) && (in_data <= PRINT_MAX);
      is_nl    = accept && ((is_print && col == LAST_COL) || in_data == CH_LF);
   end

   // console state machine: clears, cursor/scroll bookkeeping and the registered tram port
   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         state     <= ST_CLR_ALL;
         col       <= '0;
         row       <= '0;
         line_base <= '0;
         scroll    <= '0;
         clr_cnt   <= '0;
         tram_we   <= '0;
         tram_addr <= '0;
         tram_din  <= '0;
      end else begin
         tram_we <= '0;
         case (state)
            ST_CLR_ALL: begin
               tram_we   <= '1;
               tram_addr <= clr_cnt;
               tram_din  <= blank;
               if (clr_cnt == LAST_WORD) begin
                  clr_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            ST_CLR_LINE: begin
               // line_base already points at the freshly exposed bottom line
               tram_we   <= '1;
               tram_addr <= wrap_add(line_base, clr_cnt);
               tram_din  <= blank;
               if (clr_cnt == LAST_LCNT) begin
                  clr_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  if (is_print) begin
                     tram_we   <= '1;
                     tram_addr <= wrap_add(line_base, TRAM_ADDRW'(col));
                     tram_din  <= mk_word(in_data, colr_fg, colr_bg);
                     col       <= (col == LAST_COL) ? 7'd0 : col + 7'd1;
                  end else if (in_data == CH_CR || in_data == CH_LF) begin
                     col <= '0;
                  end else if (in_data == CH_BS) begin
                     if (col != 7'd0) begin
                        tram_we   <= '1;
                        tram_addr <= wrap_add(line_base, TRAM_ADDRW'(col - 7'd1));
                        tram_din  <= blank;
                        col       <= col - 7'd1;
                     end
                  end else if (in_data == CH_FF) begin
                     col       <= '0;
                     row       <= '0;
                     line_base <= '0;
                     scroll    <= '0;
                     clr_cnt   <= '0;
                     state     <= ST_CLR_ALL;
                  end
                  // newline: step down a row, or scroll once the bottom row is full
                  if (is_nl) begin
                     line_base <= wrap_add(line_base, HRES_A);
                     if (row != LAST_ROW) begin
                        row <= row + 5'd1;
                     end else begin
                        scroll  <= wrap_add(scroll, HRES_A);
                        clr_cnt <= '0;
                        state   <= ST_CLR_LINE;
                     end
                  end
               end
            end
            default: begin
               clr_cnt <= '0;
               state   <= ST_CLR_ALL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: directed steps plus randomized bytes
// compared against a screen-level model (2-D character grid, scroll by row shift).
module tb_text_console;

   logic        clk_sys = 1'b0;
   logic        rst_sys;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  colr_fg, colr_bg;
   logic [3:0]  tram_we;
   logic [10:0] tram_addr;
   logic [31:0] tram_din;
   logic [10:0] scroll_offs;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;

   text_console dut (
      .clk_sys(clk_sys), .rst_sys(rst_sys), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .colr_fg(colr_fg), .colr_bg(colr_bg), .tram_we(tram_we),
      .tram_addr(tram_addr), .tram_din(tram_din), .scroll_offs(scroll_offs),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   // memory image of what the DUT has written into tram
   logic [31:0] shadow [0:2047];
   always @(posedge clk_sys) if (tram_we != 4'h0) shadow[tram_addr] <= tram_din;

   // reference model: visible screen as rows x cols, plus cursor and scroll
   logic [31:0] scr [0:23][0:83];
   int mcol, mrow, mscroll;
   int n_chk = 0, n_pass = 0;

   function automatic logic [31:0] mkw(input logic [7:0] g, input logic [3:0] f, input logic [3:0] b);
      return {16'h0, b, f, g};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic model_clear_all;
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 84; c++) scr[r][c] = mkw(8'h20, colr_fg, colr_bg);
      mcol = 0; mrow = 0; mscroll = 0;
   endtask

   task automatic model_newline;
      if (mrow < 23) mrow++;
      else begin
         for (int r = 0; r < 23; r++)
            for (int c = 0; c < 84; c++) scr[r][c] = scr[r+1][c];
         for (int c = 0; c < 84; c++) scr[23][c] = mkw(8'h20, colr_fg, colr_bg);
         mscroll = (mscroll + 84) % 2016;
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         scr[mrow][mcol] = mkw(b, colr_fg, colr_bg);
         mcol++;
         if (mcol == 84) begin mcol = 0; model_newline(); end
      end else if (b == 8'h0D) mcol = 0;
      else if (b == 8'h0A) begin mcol = 0; model_newline(); end
      else if (b == 8'h08) begin
         if (mcol > 0) begin mcol--; scr[mrow][mcol] = mkw(8'h20, colr_fg, colr_bg); end
      end else if (b == 8'h0C) model_clear_all();
   endtask

   function automatic int cell_addr(input int r, input int c);
      return (mscroll + r * 84 + c) % 2016;
   endfunction

   task automatic wait_ready;
      int n = 0;
      while (!in_ready && n < 5000) begin tick(); n++; end
      if (!in_ready) chk("ready_timeout", {31'h0, in_ready}, 32'h1);
   endtask

   task automatic send(input logic [7:0] b, input logic [3:0] f, input logic [3:0] bk);
      wait_ready();
      colr_fg = f; colr_bg = bk; in_data = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      model_byte(b);
   endtask

   // follow a clear that just started: every write must be a blank at base+k
   task automatic watch_clear(input string tag, input int len, input int base);
      int lowcnt = 0, k = 0, bad = 0;
      logic [31:0] bw;
      bw = mkw(8'h20, colr_fg, colr_bg);
      while (!in_ready && lowcnt < 5000) begin
         tick(); lowcnt++;
         if (tram_we != 4'h0) begin
            if (tram_we != 4'hF || int'(tram_addr) != (base + k) % 2016 || tram_din != bw) bad++;
            k++;
         end
      end
      chk({tag, "_ready_low"}, lowcnt, len);
      chk({tag, "_writes"}, k, len);
      chk({tag, "_bad_writes"}, bad, 0);
   endtask

   task automatic chk_screen(input string tag);
      int bad = 0;
      wait_ready();
      tick();
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 84; c++)
            if (shadow[cell_addr(r, c)] !== scr[r][c]) bad++;
      chk({tag, "_screen"}, bad, 0);
      chk({tag, "_col"}, cursor_col, mcol);
      chk({tag, "_row"}, cursor_row, mrow);
      chk({tag, "_scroll"}, scroll_offs, mscroll);
   endtask

   initial begin
      int lows, exp_a;
      logic [7:0] b;
      rst_sys = 1'b1; in_valid = 1'b0; in_data = 8'h00; colr_fg = 4'hF; colr_bg = 4'h0;
      repeat (3) tick();
      chk("rst_we", tram_we, 4'h0);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b1);
      rst_sys = 1'b0;
      model_clear_all();
      watch_clear("init_clear", 2016, 0);
      chk("init_ready", in_ready, 1'b1);
      chk_screen("init");

      // single character with new colours
      send(8'h41, 4'hF, 4'h1);
      chk("a_we", tram_we, 4'hF);
      chk("a_addr", tram_addr, 11'd0);
      chk("a_din", tram_din, 32'h00001F41);
      chk("a_col", cursor_col, 7'd1);

      // 85 printables back-to-back from (0,0): wraps onto row 1
      send(8'h0D, 4'hF, 4'h1);
      lows = 0; exp_a = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 85; i++) begin
         in_data = 8'($urandom_range(32, 126));
         if (!in_ready) lows++;
         exp_a = cell_addr(mrow, mcol);
         tick();
         model_byte(in_data);
      end
      in_valid = 1'b0;
      chk("b2b_ready_low", lows, 0);
      chk("b2b_last_addr", tram_addr, exp_a);
      chk("b2b_last_addr_84", tram_addr, 11'd84);
      chk("b2b_col", cursor_col, 7'd1);
      chk("b2b_row", cursor_row, 5'd1);
      chk_screen("b2b");

      // walk down to the bottom row, then scroll twice
      while (mrow < 23) send(8'h0A, 4'h7, 4'h2);
      send(8'h0A, 4'h7, 4'h2);
      chk("scroll1_offs", scroll_offs, 11'd84);
      watch_clear("scroll1", 84, cell_addr(23, 0));
      chk("scroll1_col", cursor_col, 7'd0);
      chk("scroll1_row", cursor_row, 5'd23);
      send(8'h5A, 4'h7, 4'h2);
      chk("scroll1_char_addr", tram_addr, 11'd0);
      send(8'h0A, 4'h7, 4'h2);
      chk("scroll2_offs", scroll_offs, 11'd168);
      watch_clear("scroll2", 84, 84);
      chk_screen("scroll");

      // backspace at column 0 does nothing
      send(8'h08, 4'h3, 4'h4);
      chk("bs0_we", tram_we, 4'h0);
      chk("bs0_col", cursor_col, 7'd0);
      chk("bs0_row", cursor_row, 5'd23);

      // form feed mid-screen: full clear and scroll reset
      send(8'h0C, 4'h3, 4'h4);
      chk("ff_scroll", scroll_offs, 11'd0);
      chk("ff_busy", busy, 1'b1);
      watch_clear("ff", 2016, 0);
      chk_screen("ff");

      // backspace at (row 2, col 5)
      send(8'h0A, 4'h3, 4'h4);
      send(8'h0A, 4'h3, 4'h4);
      for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 4'h3, 4'h4);
      send(8'h08, 4'h5, 4'h6);
      chk("bs_we", tram_we, 4'hF);
      chk("bs_addr", tram_addr, 11'd172);
      chk("bs_din", tram_din, mkw(8'h20, 4'h5, 4'h6));
      chk("bs_col", cursor_col, 7'd4);
      chk_screen("bs");

      // randomized byte stream with gaps and colour changes
      for (int i = 0; i < 700; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 70) b = 8'($urandom_range(32, 126));
         else if (r < 80) b = 8'h0A;
         else if (r < 85) b = 8'h0D;
         else if (r < 92) b = 8'h08;
         else begin
            b = 8'($urandom_range(0, 255));
            if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0A || b == 8'h0D || b == 8'h08 || b == 8'h0C)
               b = 8'h7F;
         end
         repeat ($urandom_range(0, 2)) tick();
         send(b, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if (i % 100 == 99) chk_screen("rand");
      end

      // reset asserted in the middle of a line clear
      colr_fg = 4'hA; colr_bg = 4'h5;
      while (mrow < 23) send(8'h0A, 4'hA, 4'h5);
      wait_ready();
      in_data = 8'h0A; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      chk("midclr_busy", busy, 1'b1);
      rst_sys = 1'b1;
      tick();
      chk("rstclr_we", tram_we, 4'h0);
      chk("rstclr_ready", in_ready, 1'b0);
      chk("rstclr_scroll", scroll_offs, 11'd0);
      chk("rstclr_col", cursor_col, 7'd0);
      chk("rstclr_row", cursor_row, 5'd0);
      rst_sys = 1'b0;
      model_clear_all();
      tick();
      chk("rstclr_we0", tram_we, 4'hF);
      chk("rstclr_addr0", tram_addr, 11'd0);
      tick();
      chk("rstclr_addr1", tram_addr, 11'd1);
      chk_screen("rstclr");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
